fixp_phase_counter: RTL and testbench

Parametrised fixed-point phase counter. It is the next generation of the PSK modulator's symbol/phase timing counter. It accumulates an unsigned Q(INT_W,FRAC_W) step against a programmable modulus, with selectable wrap behaviour and a one-shot mode. A ready/valid step-update port applies a new step only at a wrap boundary, so the phase stays continuous. It sits between the modulator control registers and the phase-to-symbol lookup.

---
 rtl/fixp_pkg.sv | 19 +
 rtl/fixp_step_shadow.sv | 50 +++++
 rtl/fixp_phase_counter.sv | 121 ++++++++++++
 tb/tb_fixp_phase_counter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixp_pkg.sv
// Shared encodings and default widths for the fixed-point phase counter.
package fixp_pkg;

    localparam int FIXP_INT_W  = 8;
    localparam int FIXP_FRAC_W = 8;

    typedef enum logic [1:0] {
        FIXP_MODE_WRAP_ZERO = 2'd0,
        FIXP_MODE_WRAP_REM  = 2'd1,
        FIXP_MODE_ONE_SHOT  = 2'd2,
        FIXP_MODE_RESERVED  = 2'd3
    } fixp_mode_e;

    typedef enum logic {
        FIXP_ST_IDLE = 1'b0,
        FIXP_ST_RUN  = 1'b1
    } fixp_state_e;

endpackage

// File: rtl/fixp_step_shadow.sv
// Single-entry shadow register for step updates; the parent decides when
// the held value is consumed into the active step.
module fixp_step_shadow
    import fixp_pkg::*;
#(
    parameter int W = FIXP_INT_W + FIXP_FRAC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] step_in,
    input  logic         step_valid,
    input  logic         consume,
    output logic         step_ready,
    output logic         pending,
    output logic [W-1:0] shadow_val
);

    // Handshake: a transfer happens on any rising edge where step_valid and
    // step_ready are both high; step_ready is registered (not-pending), so it
    // never depends combinationally on step_valid or consume.
    logic         pending_q, pending_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic         transfer;

    assign transfer = step_valid && !pending_q;

    always_comb begin
        pending_d = pending_q && !consume;
        shadow_d  = shadow_q;
        if (transfer) begin
            pending_d = 1'b1;
            shadow_d  = step_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 1'b0;
            shadow_q  <= '0;
        end else begin
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
        end
    end

    assign step_ready = !pending_q;
    assign pending    = pending_q;
    assign shadow_val = shadow_q;

endmodule

// File: rtl/fixp_phase_counter.sv
// Fixed-point phase accumulator with programmable modulus, selectable wrap
// behaviour and a step shadow that only takes effect at wrap/idle boundaries.
module fixp_phase_counter
    import fixp_pkg::*;
#(
    parameter int  INT_W  = FIXP_INT_W,
    parameter int  FRAC_W = FIXP_FRAC_W,
    localparam int W      = INT_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     modulus,
    input  logic             start,
    input  logic             clear,
    input  logic [W-1:0]     step_in,
    input  logic             step_valid,
    output logic             step_ready,
    output logic [W-1:0]     count_out,
    output logic [INT_W-1:0] int_out,
    output logic             wrap_pulse,
    output logic             busy,
    output logic             state_dbg
);

    fixp_state_e  state_q, state_d;
    fixp_mode_e   mode_e;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] active_step_q, active_step_d;
    logic         wrap_q, wrap_d;
    logic         consume;
    logic         shadow_pending;
    logic [W-1:0] shadow_val;

    logic [W:0]   sum;
    logic [W-1:0] rem;
    logic         wrap_hit;
    logic         run_adv;

    assign mode_e = fixp_mode_e'(mode);

    // One extra bit on the sum so count + step can never alias below modulus.
    assign sum      = {1'b0, count_q} + {1'b0, active_step_q};
    assign rem      = sum[W-1:0] - modulus;
    assign wrap_hit = (sum >= {1'b0, modulus});
    assign run_adv  = (state_q == FIXP_ST_RUN) && clk_en && !clear && !start;

    fixp_step_shadow #(.W(W)) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .step_in    (step_in),
        .step_valid (step_valid),
        .consume    (consume),
        .step_ready (step_ready),
        .pending    (shadow_pending),
        .shadow_val (shadow_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FIXP_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = FIXP_ST_IDLE;
        end else if (start) begin
            state_d = FIXP_ST_RUN;
        end else if (run_adv && wrap_hit && mode_e == FIXP_MODE_ONE_SHOT) begin
            state_d = FIXP_ST_IDLE;
        end
    end

    always_comb begin
        count_d       = count_q;
        wrap_d        = 1'b0;
        active_step_d = active_step_q;
        if (clear || start) begin
            count_d = '0;
        end else if (run_adv) begin
            if (wrap_hit) begin
                wrap_d = 1'b1;
                case (mode_e)
                    FIXP_MODE_WRAP_REM: count_d = rem;
                    default:            count_d = '0;
                endcase
            end else begin
                count_d = sum[W-1:0];
            end
        end
        // Phase continuity: a new step only lands at a wrap or while idle.
        consume = shadow_pending && ((state_q == FIXP_ST_IDLE) || (run_adv && wrap_hit));
        if (consume) begin
            active_step_d = shadow_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q       <= '0;
            active_step_q <= '0;
            wrap_q        <= 1'b0;
        end else begin
            count_q       <= count_d;
            active_step_q <= active_step_d;
            wrap_q        <= wrap_d;
        end
    end

    assign count_out  = count_q;
    assign int_out    = count_q[W-1:FRAC_W];
    assign wrap_pulse = wrap_q;
    assign busy       = (state_q == FIXP_ST_RUN);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_fixp_phase_counter.sv
// Directed bench for fixp_phase_counter: literal sequences plus a per-cycle
// comparison against an arithmetic reference model.
module tb_fixp_phase_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en;
  logic [1:0]  mode;
  logic [15:0] modulus;
  logic        start;
  logic        clear;
  logic [15:0] step_in;
  logic        step_valid;
  logic        step_ready;
  logic [15:0] count_out;
  logic [7:0]  int_out;
  logic        wrap_pulse;
  logic        busy;
  logic        state_dbg;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_count = 0;
  int m_step = 0;
  int m_shadow = 0;
  bit m_pending = 0;
  bit m_run = 0;
  bit m_wrap = 0;

  fixp_phase_counter dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .mode       (mode),
    .modulus    (modulus),
    .start      (start),
    .clear      (clear),
    .step_in    (step_in),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .count_out  (count_out),
    .int_out    (int_out),
    .wrap_pulse (wrap_pulse),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: outputs follow directly from the phase arithmetic rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count <= 0;
      m_step <= 0;
      m_shadow <= 0;
      m_pending <= 0;
      m_run <= 0;
      m_wrap <= 0;
    end else begin
      int c, s, sh, total;
      bit r, p, w;
      c = m_count; s = m_step; sh = m_shadow; r = m_run; p = m_pending; w = 0;
      if (clear) begin
        r = 0; c = 0;
      end else if (start) begin
        r = 1; c = 0;
      end else if (m_run && clk_en) begin
        total = m_count + m_step;
        if (total >= int'(modulus)) begin
          w = 1;
          if (mode == 2'd1) c = (total - int'(modulus)) % 65536;
          else c = 0;
          if (mode == 2'd2) r = 0;
        end else begin
          c = total;
        end
      end
      if (m_pending && (!m_run || w)) begin
        s = m_shadow; p = 0;
      end
      if (step_valid && !m_pending) begin
        sh = int'(step_in); p = 1;
      end
      m_count <= c; m_step <= s; m_shadow <= sh; m_run <= r; m_pending <= p; m_wrap <= w;
    end
  end

  always @(negedge clk) begin
    chk("mdl_count", {16'd0, count_out}, m_count);
    chk("mdl_int", {24'd0, int_out}, m_count / 256);
    chk("mdl_wrap", {31'd0, wrap_pulse}, {31'd0, m_wrap});
    chk("mdl_busy", {31'd0, busy}, {31'd0, m_run});
    chk("mdl_ready", {31'd0, step_ready}, {31'd0, !m_pending});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cw(input logic [15:0] c, input logic w);
    tick();
    chk("seq_count", {16'd0, count_out}, {16'd0, c});
    chk("seq_wrap", {31'd0, wrap_pulse}, {31'd0, w});
  endtask

  task automatic load_step(input logic [15:0] v);
    step_in = v;
    step_valid = 1;
    tick();
    step_valid = 0;
    tick();
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    chk("start_count", {16'd0, count_out}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
    chk("clear_busy", {31'd0, busy}, 32'd0);
    chk("clear_count", {16'd0, count_out}, 32'd0);
  endtask

  initial begin
    clk_en = 0; mode = 0; modulus = 0; start = 0; clear = 0;
    step_in = 0; step_valid = 0;
    #1 rst = 0;
    #20;
    chk("rst_count", {16'd0, count_out}, 32'd0);
    chk("rst_int", {24'd0, int_out}, 32'd0);
    chk("rst_wrap", {31'd0, wrap_pulse}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, step_ready}, 32'd1);
    #1 rst = 1;
    tick();

    // WRAP_ZERO, step 0x40, modulus 0x100
    mode = 2'd0; modulus = 16'h0100; clk_en = 1;
    load_step(16'h0040);
    do_start();
    expect_cw(16'h0040, 0); expect_cw(16'h0080, 0); expect_cw(16'h00C0, 0); expect_cw(16'h0000, 1);
    expect_cw(16'h0040, 0); expect_cw(16'h0080, 0); expect_cw(16'h00C0, 0); expect_cw(16'h0000, 1);
    do_clear();

    // WRAP_REM, step 0x60, modulus 0x100
    mode = 2'd1;
    load_step(16'h0060);
    do_start();
    expect_cw(16'h0060, 0); expect_cw(16'h00C0, 0); expect_cw(16'h0020, 1);
    expect_cw(16'h0080, 0); expect_cw(16'h00E0, 0); expect_cw(16'h0040, 1);
    do_clear();

    // integer part: step 1.5, modulus 4.0 -> wraps every 3 cycles
    mode = 2'd0; modulus = 16'h0400;
    load_step(16'h0180);
    do_start();
    expect_cw(16'h0180, 0);
    chk("int_1", {24'd0, int_out}, 32'd1);
    expect_cw(16'h0300, 0);
    chk("int_3", {24'd0, int_out}, 32'd3);
    expect_cw(16'h0000, 1);
    do_clear();

    // step update mid-run
    modulus = 16'h0100;
    load_step(16'h0040);
    do_start();
    expect_cw(16'h0040, 0);
    step_in = 16'h0080; step_valid = 1;
    expect_cw(16'h0080, 0);
    step_valid = 0;
    chk("upd_ready_low", {31'd0, step_ready}, 32'd0);
    expect_cw(16'h00C0, 0);
    chk("upd_ready_hold", {31'd0, step_ready}, 32'd0);
    expect_cw(16'h0000, 1);
    expect_cw(16'h0080, 0);
    chk("upd_ready_back", {31'd0, step_ready}, 32'd1);
    expect_cw(16'h0000, 1);
    expect_cw(16'h0080, 0);
    do_clear();

    // ONE_SHOT, step 0x80
    mode = 2'd2;
    load_step(16'h0080);
    do_start();
    expect_cw(16'h0080, 0);
    expect_cw(16'h0000, 1);
    chk("os_busy_drop", {31'd0, busy}, 32'd0);
    expect_cw(16'h0000, 0);
    expect_cw(16'h0000, 0);
    chk("os_idle_busy", {31'd0, busy}, 32'd0);
    do_start();
    expect_cw(16'h0080, 0);
    expect_cw(16'h0000, 1);
    chk("os_busy_drop2", {31'd0, busy}, 32'd0);

    // clk_en freeze, then restart while running
    mode = 2'd0;
    load_step(16'h0040);
    do_start();
    expect_cw(16'h0040, 0);
    clk_en = 0;
    expect_cw(16'h0040, 0); expect_cw(16'h0040, 0); expect_cw(16'h0040, 0);
    clk_en = 1;
    expect_cw(16'h0080, 0);
    do_start();
    expect_cw(16'h0040, 0);

    // a pending shadow survives clear and lands on the next idle edge
    step_in = 16'h0020; step_valid = 1;
    expect_cw(16'h0080, 0);
    step_valid = 0;
    do_clear();
    do_start();
    expect_cw(16'h0020, 0);

    // start and clear on the same edge: clear wins
    start = 1; clear = 1;
    tick();
    start = 0; clear = 0;
    chk("sc_busy", {31'd0, busy}, 32'd0);
    chk("sc_count", {16'd0, count_out}, 32'd0);

    // modulus 0 wraps on every enabled cycle
    modulus = 16'h0000;
    do_start();
    expect_cw(16'h0000, 1); expect_cw(16'h0000, 1); expect_cw(16'h0000, 1);
    do_clear();
    modulus = 16'h0100;

    // zero step never wraps
    load_step(16'h0000);
    do_start();
    expect_cw(16'h0000, 0); expect_cw(16'h0000, 0); expect_cw(16'h0000, 0);
    do_clear();

    // asynchronous reset between edges
    load_step(16'h0040);
    do_start();
    expect_cw(16'h0040, 0);
    expect_cw(16'h0080, 0);
    #2 rst = 0;
    #1;
    chk("arst_count", {16'd0, count_out}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wrap", {31'd0, wrap_pulse}, 32'd0);
    chk("arst_ready", {31'd0, step_ready}, 32'd1);
    @(negedge clk);
    #2 rst = 1;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_count", {16'd0, count_out}, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
